filtro_secuenciador: RTL and testbench

//  Control FSM for the time-multiplexed recursive (IIR, direct-form I) filter datapath.
//  - On each audio sample tick it steps one shared multiplier/accumulator through all taps.
//  - It then pulses the load enables of the filter state registers (x/y delay line, output register).
//  - It flags ticks that arrive while a sample is still in progress.

---
 rtl/filtro_pkg.sv | 36 +++
 rtl/filtro_secuenciador_if.sv | 31 +++
 rtl/filtro_tap_counter.sv | 32 +++
 rtl/filtro_secuenciador.sv | 158 +++++++++++++++
 tb/tb_filtro_secuenciador.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/filtro_pkg.sv
// Shared definitions for the IIR filter sequencer: state encoding, tap codes and defaults.
package filtro_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLR    = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_UPDATE = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        CLR    = ST_CLR,
        ISSUE  = ST_ISSUE,
        DRAIN  = ST_DRAIN,
        UPDATE = ST_UPDATE,
        DONE   = ST_DONE
    } state_t;

    // Tap order on the coefficient ROM mux: feed-forward first, then feedback.
    localparam int TAP_B0 = 0;
    localparam int TAP_B1 = 1;
    localparam int TAP_B2 = 2;
    localparam int TAP_A1 = 3;
    localparam int TAP_A2 = 4;

    localparam int DEF_NUM_TAPS = 5;
    localparam int DEF_MAC_LAT  = 2;
    localparam int DEF_TAP_W    = 4;

    // The shared counter also times the DRAIN wait, so it needs room for MAC_LAT-1 (up to 6).
    function automatic int cnt_width(input int tap_w);
        return (tap_w > 3) ? tap_w : 3;
    endfunction

endpackage

// File: rtl/filtro_secuenciador_if.sv
// Control bundle between the sample-tick source, the sequencer and the MAC datapath.
interface filtro_secuenciador_if
    import filtro_pkg::*;
#(
    parameter int TAP_W = DEF_TAP_W
) ();

    logic             run;
    logic             sample_tick;
    logic             err_clr;
    logic [TAP_W-1:0] tap_sel;
    logic             mac_issue;
    logic             acc_clr;
    logic             acc_en;
    logic             en_out;
    logic             en_shift;
    logic             out_valid;
    logic             busy;
    logic             overrun;

    modport master (
        output run, sample_tick, err_clr,
        input  tap_sel, mac_issue, acc_clr, acc_en, en_out, en_shift, out_valid, busy, overrun
    );

    modport slave (
        input  run, sample_tick, err_clr,
        output tap_sel, mac_issue, acc_clr, acc_en, en_out, en_shift, out_valid, busy, overrun
    );

endinterface

// File: rtl/filtro_tap_counter.sv
// Loadable up-counter with terminal-count flag; walks the taps in ISSUE and times DRAIN.
module filtro_tap_counter
    import filtro_pkg::*;
#(
    parameter int W = cnt_width(DEF_TAP_W)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_inc,
    input  logic [W-1:0] i_last,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_last);

endmodule

// File: rtl/filtro_secuenciador.sv
// Sequencer for the time-multiplexed direct-form I IIR filter: one MAC pass per sample tick.
module filtro_secuenciador
    import filtro_pkg::*;
#(
    parameter int NUM_TAPS = DEF_NUM_TAPS,
    parameter int MAC_LAT  = DEF_MAC_LAT,
    parameter int TAP_W    = DEF_TAP_W
) (
    input  logic                  clk,
    input  logic                  reset,
    filtro_secuenciador_if.slave  bus
);

    localparam int CNT_W = cnt_width(TAP_W);

    state_t           r_state;
    state_t           w_nxt_state;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_tc;
    logic             w_cnt_load;
    logic             w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_last;
    logic             w_tick_ok;
    logic             w_ovr_set;
    logic [TAP_W-1:0] w_tap_nxt;
    logic             w_acc_en;

    logic             r_acc_clr;
    logic             r_mac_issue;
    logic [TAP_W-1:0] r_tap_sel;
    logic             r_en_upd;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_overrun;

    assign w_tick_ok = bus.sample_tick & bus.run;

    filtro_tap_counter #(.W(CNT_W)) u_tap_counter (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (CNT_W'(TAP_B0)),
        .i_inc      (w_cnt_inc),
        .i_last     (w_cnt_last),
        .o_cnt      (w_cnt),
        .o_tc       (w_cnt_tc)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_inc   = 1'b0;
        w_cnt_last  = CNT_W'(NUM_TAPS - 1);
        w_ovr_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_tick_ok) begin
                    w_nxt_state = CLR;
                    w_cnt_load  = 1'b1;
                end
            end
            CLR: begin
                w_ovr_set   = bus.sample_tick;
                w_nxt_state = ISSUE;
            end
            ISSUE: begin
                w_ovr_set = bus.sample_tick;
                if (w_cnt_tc) begin
                    // With no multiplier pipeline the last product is already accumulated.
                    w_nxt_state = (MAC_LAT == 0) ? UPDATE : DRAIN;
                    w_cnt_load  = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            DRAIN: begin
                w_ovr_set  = bus.sample_tick;
                w_cnt_last = CNT_W'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);
                if (w_cnt_tc) begin
                    w_nxt_state = UPDATE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            UPDATE: begin
                w_ovr_set   = bus.sample_tick;
                w_nxt_state = DONE;
            end
            DONE: begin
                if (w_tick_ok) begin
                    w_nxt_state = CLR;
                    w_cnt_load  = 1'b1;
                end else begin
                    w_nxt_state = IDLE;
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    assign w_tap_nxt = (r_state == ISSUE) ? TAP_W'(w_cnt + 1'b1) : TAP_W'(TAP_B0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_acc_clr   <= 1'b0;
            r_mac_issue <= 1'b0;
            r_tap_sel   <= '0;
            r_en_upd    <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_acc_clr   <= (w_nxt_state == CLR);
            r_mac_issue <= (w_nxt_state == ISSUE);
            if (w_nxt_state == ISSUE) begin
                r_tap_sel <= w_tap_nxt;
            end
            r_en_upd    <= (w_nxt_state == UPDATE);
            r_out_valid <= (w_nxt_state == DONE);
            r_busy      <= (w_nxt_state != IDLE);
            r_overrun   <= w_ovr_set | (r_overrun & ~bus.err_clr);
        end
    end

    // acc_en follows mac_issue through the multiplier pipeline depth.
    generate
        if (MAC_LAT == 0) begin : g_no_dly
            assign w_acc_en = r_mac_issue;
        end else begin : g_dly
            logic [MAC_LAT-1:0] r_dly;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_dly <= '0;
                end else begin
                    r_dly[0] <= r_mac_issue;
                    for (int i = 1; i < MAC_LAT; i++) begin
                        r_dly[i] <= r_dly[i-1];
                    end
                end
            end
            assign w_acc_en = r_dly[MAC_LAT-1];
        end
    endgenerate

    assign bus.tap_sel   = r_tap_sel;
    assign bus.mac_issue = r_mac_issue;
    assign bus.acc_clr   = r_acc_clr;
    assign bus.acc_en    = w_acc_en;
    assign bus.en_out    = r_en_upd;
    assign bus.en_shift  = r_en_upd;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_filtro_secuenciador.sv
// Bench for filtro_secuenciador: default build (5 taps, latency 2) and a 3-tap zero-latency build.
module tb_filtro_secuenciador;

    logic clk;
    logic rst_n;
    logic run;
    logic tick;
    logic err_clr;

    int checks;
    int errors;
    int ov_cnt [2];
    int en_cnt0;

    filtro_secuenciador_if #(.TAP_W(4)) if0 ();
    filtro_secuenciador_if #(.TAP_W(2)) if1 ();

    assign if0.run = run;  assign if0.sample_tick = tick;  assign if0.err_clr = err_clr;
    assign if1.run = run;  assign if1.sample_tick = tick;  assign if1.err_clr = err_clr;

    filtro_secuenciador #(.NUM_TAPS(5), .MAC_LAT(2), .TAP_W(4)) u_dut0 (
        .clk(clk), .reset(rst_n), .bus(if0)
    );
    filtro_secuenciador #(.NUM_TAPS(3), .MAC_LAT(0), .TAP_W(2)) u_dut1 (
        .clk(clk), .reset(rst_n), .bus(if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nt(input int i);
        return (i == 0) ? 5 : 3;
    endfunction
    function automatic int ml(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    // Reference model: position k inside the current sample (0 = idle, 1 = acc_clr cycle,
    // NUM_TAPS+MAC_LAT+3 = out_valid cycle) plus the sticky overrun and last issued tap.
    bit m_act [2];
    int m_k   [2];
    bit m_ovr [2];
    int m_tap [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] <= 1'b0; m_k[i] <= 0; m_ovr[i] <= 1'b0; m_tap[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                automatic int p    = nt(i) + ml(i) + 3;
                automatic bit free = !m_act[i] || (m_k[i] == p);
                if (tick && run && free) begin
                    m_act[i] <= 1'b1; m_k[i] <= 1;
                end else if (m_act[i]) begin
                    if (m_k[i] == p) begin
                        m_act[i] <= 1'b0; m_k[i] <= 0;
                    end else begin
                        m_k[i] <= m_k[i] + 1;
                    end
                end
                m_ovr[i] <= (tick && !free) || (m_ovr[i] && !err_clr);
                if (m_act[i] && !(tick && run && free) && m_k[i] >= 1 && m_k[i] <= nt(i))
                    m_tap[i] <= m_k[i] - 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            logic [31:0] g_tap;
            logic g_iss, g_clr, g_acc, g_eo, g_es, g_ov, g_busy, g_ovr;
            int k, n, l, p;
            if (i == 0) begin
                g_tap = 32'(if0.tap_sel); g_iss = if0.mac_issue; g_clr = if0.acc_clr;
                g_acc = if0.acc_en; g_eo = if0.en_out; g_es = if0.en_shift;
                g_ov = if0.out_valid; g_busy = if0.busy; g_ovr = if0.overrun;
            end else begin
                g_tap = 32'(if1.tap_sel); g_iss = if1.mac_issue; g_clr = if1.acc_clr;
                g_acc = if1.acc_en; g_eo = if1.en_out; g_es = if1.en_shift;
                g_ov = if1.out_valid; g_busy = if1.busy; g_ovr = if1.overrun;
            end
            k = m_k[i]; n = nt(i); l = ml(i); p = n + l + 3;
            chk($sformatf("d%0d_busy", i),      32'(g_busy), 32'(m_act[i]));
            chk($sformatf("d%0d_acc_clr", i),   32'(g_clr),  32'(k == 1));
            chk($sformatf("d%0d_mac_issue", i), 32'(g_iss),  32'(k >= 2 && k <= n + 1));
            chk($sformatf("d%0d_tap_sel", i),   g_tap,       32'(m_tap[i]));
            chk($sformatf("d%0d_acc_en", i),    32'(g_acc),  32'(k >= 2 + l && k <= n + 1 + l));
            chk($sformatf("d%0d_en_out", i),    32'(g_eo),   32'(k == n + 2 + l));
            chk($sformatf("d%0d_en_shift", i),  32'(g_es),   32'(k == n + 2 + l));
            chk($sformatf("d%0d_out_valid", i), 32'(g_ov),   32'(k == p));
            chk($sformatf("d%0d_overrun", i),   32'(g_ovr),  32'(m_ovr[i]));
            if (g_ov === 1'b1) ov_cnt[i]++;
            if (i == 0 && g_eo === 1'b1) en_cnt0++;
        end
    endtask

    // One clock: compare on the falling edge, then move to just after the next rising edge.
    task automatic cyc();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0; errors = 0; ov_cnt[0] = 0; ov_cnt[1] = 0; en_cnt0 = 0;
        rst_n = 1'b0; run = 1'b0; tick = 1'b0; err_clr = 1'b0;
        repeat (3) cyc();
        chk("rst_busy", 32'(if0.busy), 0);
        chk("rst_tap_sel", 32'(if0.tap_sel), 0);
        chk("rst_acc_en", 32'(if0.acc_en), 0);
        rst_n = 1'b1; run = 1'b1;
        repeat (2) cyc();

        // Single sample: hand-timed positions for both builds.
        tick = 1'b1; cyc(); tick = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            chk($sformatf("t1_d0_acc_clr@%0d", j),   32'(if0.acc_clr),   32'(j == 1));
            chk($sformatf("t1_d0_mac_issue@%0d", j), 32'(if0.mac_issue), 32'(j >= 2 && j <= 6));
            if (j >= 2 && j <= 6)
                chk($sformatf("t1_d0_tap_sel@%0d", j), 32'(if0.tap_sel), 32'(j - 2));
            chk($sformatf("t1_d0_acc_en@%0d", j),    32'(if0.acc_en),    32'(j >= 4 && j <= 8));
            chk($sformatf("t1_d0_en_out@%0d", j),    32'(if0.en_out),    32'(j == 9));
            chk($sformatf("t1_d0_en_shift@%0d", j),  32'(if0.en_shift),  32'(j == 9));
            chk($sformatf("t1_d0_out_valid@%0d", j), 32'(if0.out_valid), 32'(j == 10));
            chk($sformatf("t1_d0_busy@%0d", j),      32'(if0.busy),      32'(j <= 10));
            chk($sformatf("t1_d1_mac_issue@%0d", j), 32'(if1.mac_issue), 32'(j >= 2 && j <= 4));
            chk($sformatf("t1_d1_acc_en@%0d", j),    32'(if1.acc_en),    32'(j >= 2 && j <= 4));
            chk($sformatf("t1_d1_en_out@%0d", j),    32'(if1.en_out),    32'(j == 5));
            chk($sformatf("t1_d1_out_valid@%0d", j), 32'(if1.out_valid), 32'(j == 6));
            cyc();
        end

        // Back-to-back ticks at the minimum spacing: every tick lands in DONE.
        ov_cnt[0] = 0; ov_cnt[1] = 0;
        for (int s = 0; s < 20; s++) begin
            tick = 1'b1; cyc(); tick = 1'b0;
            repeat (9) cyc();
        end
        repeat (3) cyc();
        chk("t2_d0_samples", 32'(ov_cnt[0]), 20);
        chk("t2_d1_samples", 32'(ov_cnt[1]), 20);
        chk("t2_d0_overrun", 32'(if0.overrun), 0);

        // Tick during ISSUE is dropped and flagged.
        ov_cnt[0] = 0;
        tick = 1'b1; cyc(); tick = 1'b0;
        repeat (4) cyc();
        tick = 1'b1; cyc(); tick = 1'b0;
        chk("t3_overrun_set", 32'(if0.overrun), 1);
        repeat (10) cyc();
        chk("t3_one_sample", 32'(ov_cnt[0]), 1);
        chk("t3_overrun_sticky", 32'(if0.overrun), 1);
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
        chk("t3_overrun_clr", 32'(if0.overrun), 0);
        repeat (3) cyc();

        // run drops mid-sample: sample completes, later tick ignored.
        tick = 1'b1; cyc(); tick = 1'b0;
        repeat (2) cyc();
        run = 1'b0;
        repeat (7) cyc();
        chk("t4_out_valid", 32'(if0.out_valid), 1);
        repeat (10) cyc();
        tick = 1'b1; cyc(); tick = 1'b0;
        chk("t4_busy", 32'(if0.busy), 0);
        cyc();
        chk("t4_busy_later", 32'(if0.busy), 0);
        chk("t4_overrun", 32'(if0.overrun), 0);
        run = 1'b1;
        repeat (2) cyc();

        // Asynchronous reset mid-sample aborts without register enables.
        en_cnt0 = 0;
        tick = 1'b1; cyc(); tick = 1'b0;
        repeat (5) cyc();
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(if0.busy), 0);
        chk("t5_mac_issue", 32'(if0.mac_issue), 0);
        chk("t5_acc_en", 32'(if0.acc_en), 0);
        chk("t5_tap_sel", 32'(if0.tap_sel), 0);
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (8) cyc();
        chk("t5_no_en_out", 32'(en_cnt0), 0);
        tick = 1'b1; cyc(); tick = 1'b0;
        repeat (8) cyc();
        chk("t5_en_out", 32'(if0.en_out), 1);
        chk("t5_en_shift", 32'(if0.en_shift), 1);
        cyc();
        chk("t5_out_valid", 32'(if0.out_valid), 1);
        repeat (2) cyc();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            tick    = ($urandom_range(0, 5) == 0);
            run     = ($urandom_range(0, 9) != 0);
            err_clr = ($urandom_range(0, 19) == 0);
            rst_n   = ($urandom_range(0, 499) != 0);
            cyc();
        end
        rst_n = 1'b1; tick = 1'b0;
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
